// File: rtl/sa_skew_feeder_pkg.sv
// pe_pkg: shared constants and types for the systolic array edge feeder
package pe_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LANES  = 4;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_e;
  typedef logic signed [DEF_DATA_W-1:0] lane_t;
endpackage

// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if: upstream beat handshake plus skewed PE-edge outputs
interface sa_skew_feeder_if #(parameter int DATA_W = 16, parameter int LANES = 4);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_last;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_valid;
  logic                    done;
  modport master (output in_valid, in_data, in_last, input in_ready, out_data, out_valid, done);
  modport slave  (input in_valid, in_data, in_last, output in_ready, out_data, out_valid, done);
endinterface

// File: rtl/sa_skew_feeder_delay_line.sv
// skew_delay_line: fixed-depth always-shifting register chain for one lane
module skew_delay_line #(parameter int WIDTH = 17, parameter int DEPTH = 1) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  // shift every cycle; stage 0 takes the new entry, the last stage is the output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    else begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: diagonally skews operand vectors onto the PE array edge
module sa_skew_feeder import pe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input logic             clk,
  input logic             rst_n,
  sa_skew_feeder_if.slave bus
);
  localparam int CW = $clog2(LANES + 1);
  feeder_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rdy, acc;
  assign rdy          = state != FLUSH;
  assign acc          = bus.in_valid && rdy;
  assign bus.in_ready = rdy;
  // state and flush counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // hold off input for LANES-1 cycles after a tile's last beat so the skew drains
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == FLUSH) begin
      cnt_n   = cnt - 1'b1;
      state_n = cnt == CW'(1) ? IDLE : FLUSH;
    end else if (acc) begin
      state_n = !bus.in_last ? STREAM : (LANES > 1 ? FLUSH : IDLE);
      cnt_n   = CW'(LANES - 1);
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] ld, lq;
    logic              lv;
    assign ld = acc ? bus.in_data[i*DATA_W +: DATA_W] : '0;
    assign bus.out_data[i*DATA_W +: DATA_W] = lq;
    assign bus.out_valid[i] = lv;
    if (i == LANES - 1) begin : g_tail
      skew_delay_line #(.WIDTH(DATA_W + 2), .DEPTH(i + 1)) u_dl (
        .clk(clk), .rst_n(rst_n),
        .d({acc && bus.in_last, acc, ld}),
        .q({bus.done, lv, lq})
      );
    end else begin : g_body
      skew_delay_line #(.WIDTH(DATA_W + 1), .DEPTH(i + 1)) u_dl (
        .clk(clk), .rst_n(rst_n),
        .d({acc, ld}),
        .q({lv, lq})
      );
    end
  end
endmodule
